// File: rtl/cmt_trace_pkg.sv
// Shared types for the commit trace buffer: record layout, FSM states and defaults.
// The per-record cycle stamp exists only when CMT_TRACE_CYCLE_EN is defined.
package cmt_trace_pkg;

  localparam int DEPTH_DEFAULT  = 8;
  localparam int DROP_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } cmt_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        exp;
    logic        mret;
    logic        rf_wen;
    logic [4:0]  rf_wnum;
    logic [63:0] rf_wdata;
    logic [63:0] seq;
`ifdef CMT_TRACE_CYCLE_EN
    logic [63:0] cycle;
`endif
  } cmt_rec_t;

endpackage

// File: rtl/commit_trace_if.sv
// Commit-in / trace-out bundle: master is the WB stage plus trace consumer, slave is commit_trace.
// out_cycle is present only when CMT_TRACE_CYCLE_EN is defined.
interface commit_trace_if;
  logic        cmt_valid;
  logic [63:0] cmt_pc;
  logic [31:0] cmt_inst;
  logic        cmt_exp;
  logic        cmt_mret;
  logic        cmt_rf_wen;
  logic [4:0]  cmt_rf_wnum;
  logic [63:0] cmt_rf_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_exp;
  logic        out_mret;
  logic        out_rf_wen;
  logic [4:0]  out_rf_wnum;
  logic [63:0] out_rf_wdata;
  logic [63:0] out_seq;
`ifdef CMT_TRACE_CYCLE_EN
  logic [63:0] out_cycle;
`endif

  modport master (
    output cmt_valid, cmt_pc, cmt_inst, cmt_exp, cmt_mret, cmt_rf_wen, cmt_rf_wnum, cmt_rf_wdata,
    output out_ready,
`ifdef CMT_TRACE_CYCLE_EN
    input  out_cycle,
`endif
    input  out_valid, out_pc, out_inst, out_exp, out_mret, out_rf_wen, out_rf_wnum, out_rf_wdata,
    input  out_seq
  );

  modport slave (
    input  cmt_valid, cmt_pc, cmt_inst, cmt_exp, cmt_mret, cmt_rf_wen, cmt_rf_wnum, cmt_rf_wdata,
    input  out_ready,
`ifdef CMT_TRACE_CYCLE_EN
    output out_cycle,
`endif
    output out_valid, out_pc, out_inst, out_exp, out_mret, out_rf_wen, out_rf_wnum, out_rf_wdata,
    output out_seq
  );
endinterface

// File: rtl/cmt_fifo.sv
// Generic first-word-fall-through FIFO; the caller never pushes when full without popping.
// Pointers wrap modulo DEPTH (power of two); a separate count register gives full/empty.
module cmt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q    <= {PW{1'b0}};
      rd_q    <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (push_i) wr_q <= wr_q + PTR_ONE;
      if (pop_i)  rd_q <= rd_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});

endmodule

// File: rtl/commit_trace.sv
// Commit trace buffer: stamps retired instructions and queues them for a trace consumer.
// Define CMT_TRACE_CYCLE_EN to add a free-running cycle stamp per record (out_cycle).
module commit_trace
  import cmt_trace_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DROP_W = DROP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stop,
  commit_trace_if.slave     bus,
  output logic              halted,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [63:0]       inst_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_ONE;
  endfunction

  cmt_state_e        state_q, state_d;
  logic [63:0]       inst_cnt_q;
  logic [DROP_W-1:0] drop_q;
  logic              ovf_q;
  logic              push_s, pop_s, drop_s, full_s, empty_s;
  logic [CW-1:0]     count_s;
  cmt_rec_t          wrec_s, head_s;
`ifdef CMT_TRACE_CYCLE_EN
  logic [63:0]       cyc_q;

  // Free-running cycle stamp
  always_ff @(posedge clk) begin
    if (!resetn) cyc_q <= 64'd0;
    else         cyc_q <= cyc_q + 64'd1;
  end
`endif

  // Handshake decode and record assembly
  always_comb begin
    pop_s  = !empty_s && bus.out_ready;
    push_s = (state_q == ST_RUN) && bus.cmt_valid && (!full_s || pop_s);
    drop_s = (state_q == ST_RUN) && bus.cmt_valid && full_s && !pop_s;
    wrec_s          = '0;
    wrec_s.pc       = bus.cmt_pc;
    wrec_s.inst     = bus.cmt_inst;
    wrec_s.exp      = bus.cmt_exp;
    wrec_s.mret     = bus.cmt_mret;
    wrec_s.rf_wen   = bus.cmt_rf_wen;
    wrec_s.rf_wnum  = bus.cmt_rf_wnum;
    wrec_s.rf_wdata = bus.cmt_rf_wdata;
    wrec_s.seq      = inst_cnt_q;
`ifdef CMT_TRACE_CYCLE_EN
    wrec_s.cycle    = cyc_q;
`endif
  end

  cmt_fifo #(.DEPTH(DEPTH), .W($bits(cmt_rec_t))) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wrec_s),
    .rdata_o (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Commit counter and overflow bookkeeping
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_cnt_q <= 64'd0;
      drop_q     <= {DROP_W{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      if (push_s) inst_cnt_q <= inst_cnt_q + 64'd1;
      if (drop_s) begin
        ovf_q  <= 1'b1;
        drop_q <= sat_inc(drop_q);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // FSM next state: drain finishes once this cycle's pop leaves the FIFO empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (stop) state_d = ST_DRAIN; else state_d = ST_RUN;
      ST_DRAIN:  if (empty_s || (count_s == CW'(1) && pop_s)) state_d = ST_HALTED;
                 else state_d = ST_DRAIN;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM and FIFO head outputs
  always_comb begin
    halted           = (state_q == ST_HALTED);
    overflow         = ovf_q;
    drop_cnt         = drop_q;
    inst_cnt         = inst_cnt_q;
    bus.out_valid    = !empty_s;
    bus.out_pc       = head_s.pc;
    bus.out_inst     = head_s.inst;
    bus.out_exp      = head_s.exp;
    bus.out_mret     = head_s.mret;
    bus.out_rf_wen   = head_s.rf_wen;
    bus.out_rf_wnum  = head_s.rf_wnum;
    bus.out_rf_wdata = head_s.rf_wdata;
    bus.out_seq      = head_s.seq;
`ifdef CMT_TRACE_CYCLE_EN
    bus.out_cycle    = head_s.cycle;
`endif
  end

endmodule

// File: tb/tb_commit_trace.sv
// Randomized bench for commit_trace against a queue-based reference model.
// Cycle-stamp checks are included when CMT_TRACE_CYCLE_EN is defined.
module tb_commit_trace;

  localparam int DEPTH = 8;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        exp;
    logic        mret;
    logic        wen;
    logic [4:0]  wnum;
    logic [63:0] wdata;
    logic [63:0] seq;
    logic [63:0] cyc;
  } exp_rec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stop = 1'b0;
  logic        halted, overflow;
  logic [15:0] drop_cnt;
  logic [63:0] inst_cnt;

  commit_trace_if bus();

  commit_trace #(.DEPTH(DEPTH), .DROP_W(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .stop     (stop),
    .bus      (bus),
    .halted   (halted),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .inst_cnt (inst_cnt)
  );

  always #5 clk = ~clk;

  exp_rec_t    mq[$];
  int          m_state = M_RUN;
  logic [63:0] m_icnt = 64'd0;
  logic [15:0] m_drop = 16'd0;
  logic        m_ovf = 1'b0;
  logic [63:0] m_cyc = 64'd0;
  int          n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("out_pc", bus.out_pc, mq[0].pc);
      check("out_inst", {32'd0, bus.out_inst}, {32'd0, mq[0].inst});
      check("out_flags", {56'd0, bus.out_exp, bus.out_mret, bus.out_rf_wen, bus.out_rf_wnum},
            {56'd0, mq[0].exp, mq[0].mret, mq[0].wen, mq[0].wnum});
      check("out_wdata", bus.out_rf_wdata, mq[0].wdata);
      check("out_seq", bus.out_seq, mq[0].seq);
`ifdef CMT_TRACE_CYCLE_EN
      check("out_cycle", bus.out_cycle, mq[0].cyc);
`endif
    end
    check("halted", {63'd0, halted}, {63'd0, m_state == M_HALT});
    check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    check("drop_cnt", {48'd0, drop_cnt}, {48'd0, m_drop});
    check("inst_cnt", inst_cnt, m_icnt);
  endtask

  task automatic rnd_fields();
    bus.cmt_pc       = {$urandom, $urandom};
    bus.cmt_inst     = $urandom;
    bus.cmt_exp      = 1'($urandom_range(0, 1));
    bus.cmt_mret     = 1'($urandom_range(0, 1));
    bus.cmt_rf_wen   = 1'($urandom_range(0, 1));
    bus.cmt_rf_wnum  = 5'($urandom_range(0, 31));
    bus.cmt_rf_wdata = {$urandom, $urandom};
  endtask

  // Drive one cycle, check current outputs, advance model and clock.
  task automatic cycle(input logic v, input logic rdy, input logic stp, input bit rf);
    exp_rec_t r;
    bit       pop;
    if (rf) rnd_fields();
    bus.cmt_valid = v;
    bus.out_ready = rdy;
    stop = stp;
    #1;
    if (resetn) check_outputs();
    if (!resetn) begin
      mq.delete();
      m_state = M_RUN; m_icnt = 64'd0; m_drop = 16'd0; m_ovf = 1'b0; m_cyc = 64'd0;
    end else begin
      pop = (mq.size() != 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (m_state == M_RUN && v) begin
        if (mq.size() < DEPTH) begin
          r.pc = bus.cmt_pc; r.inst = bus.cmt_inst; r.exp = bus.cmt_exp; r.mret = bus.cmt_mret;
          r.wen = bus.cmt_rf_wen; r.wnum = bus.cmt_rf_wnum; r.wdata = bus.cmt_rf_wdata;
          r.seq = m_icnt; r.cyc = m_cyc;
          mq.push_back(r);
          m_icnt++;
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
      end
      if (m_state == M_RUN && stp) m_state = M_DRAIN;
      else if (m_state == M_DRAIN && mq.size() == 0) m_state = M_HALT;
      m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    resetn = 1'b1;
  endtask

  int vp[4] = '{70, 90, 40, 60};
  int rp[4] = '{60, 20, 90, 50};

  initial begin
    bus.cmt_valid = 1'b0;
    bus.out_ready = 1'b0;
    rnd_fields();
    @(posedge clk);
    #1;
    do_reset();
    check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_inst_cnt", inst_cnt, 64'd0);

    // Single commit
    bus.cmt_pc = 64'h0000_0000_8000_0000;
    bus.cmt_inst = 32'h0000_0413;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("t1_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t1_pc", bus.out_pc, 64'h0000_0000_8000_0000);
    check("t1_seq", bus.out_seq, 64'd0);
    check("t1_inst_cnt", inst_cnt, 64'd1);

    // Overflow: 10 commits into a stalled 8-entry FIFO
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("t2_overflow", {63'd0, overflow}, 64'd1);
    check("t2_drop", {48'd0, drop_cnt}, 64'd2);
    check("t2_inst_cnt", inst_cnt, 64'd8);
    for (int k = 0; k < 8; k++) begin
      check("t2_seq", bus.out_seq, 64'(k));
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
    end
    check("t2_empty", {63'd0, bus.out_valid}, 64'd0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      check("t3_seq", bus.out_seq, 64'(k));
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
    end
    check("t3_drop", {48'd0, drop_cnt}, 64'd0);

    // Stop with a same-cycle commit, then drain to halt
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_inst_cnt", inst_cnt, 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("t4_not_halted", {63'd0, halted}, 64'd0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
    end
    check("t4_halted", {63'd0, halted}, 64'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    resetn = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    resetn = 1'b1;
    check("t5_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t5_inst_cnt", inst_cnt, 64'd0);
    check("t5_halted", {63'd0, halted}, 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_run_push", {63'd0, bus.out_valid}, 64'd1);
`ifdef CMT_TRACE_CYCLE_EN
    check("t5_cycle", bus.out_cycle, 64'd3);
`endif

    // Random traffic phases
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 250; i++) begin
        if (m_state == M_HALT && $urandom_range(0, 3) == 0) do_reset();
        else cycle(1'($urandom_range(0, 99) < vp[p]), 1'($urandom_range(0, 99) < rp[p]),
                   1'(p >= 2 && $urandom_range(0, 99) < 2), 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/commit_trace.md
COMMIT_TRACE -- requirements
Module: commit_trace

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, >=2).
REQ-002 SHALL have parameter DROP_W, default 16, width of the dropped-record counter.
REQ-003 SHALL have ports: clk input 1, the single clock; resetn input 1, reset (synchronous, active-low).
REQ-004 SHALL have ports: cmt_valid in 1, commit strobe from WB; cmt_pc in 64; cmt_inst in 32; cmt_exp in 1; cmt_mret in 1.
REQ-005 SHALL have ports: cmt_rf_wen in 1; cmt_rf_wnum in 5; cmt_rf_wdata in 64; stop in 1, ebreak/halt request.
REQ-006 SHALL have ports: out_valid out 1; out_ready in 1; out_pc out 64; out_inst out 32; out_exp out 1; out_mret out 1.
REQ-007 SHALL have ports: out_rf_wen out 1; out_rf_wnum out 5; out_rf_wdata out 64; out_seq out 64, commit sequence number.
REQ-008 SHALL have ports: halted out 1; overflow out 1, sticky; drop_cnt out DROP_W; inst_cnt out 64, accepted commits.

Function
REQ-009 SHALL contain states RUN, DRAIN, HALTED; state resets to RUN.
REQ-010 SHALL accept a record (push) when state==RUN, cmt_valid==1, and (count<DEPTH or pop in same cycle).
REQ-011 SHALL pop when out_valid && out_ready; out_valid = (count!=0); out_* = head entry (first-word fall-through).
REQ-012 SHALL make a record pushed at edge N visible on out_* at cycle N+1 (one-cycle latency) when FIFO was empty.
REQ-013 SHALL hold out_* and out_valid stable while out_valid && !out_ready.
REQ-014 SHALL, on simultaneous push and pop, including when full or with count==1, keep count unchanged and preserve order.
REQ-015 SHALL, on cmt_valid in RUN with count==DEPTH and no pop, drop the record, set overflow, and increment drop_cnt saturating at all-ones.
REQ-016 SHALL stamp each accepted record with out_seq = inst_cnt value before increment (first record seq 0); inst_cnt +1 per push, wraps at 2^64.
REQ-017 SHALL go RUN->DRAIN on an edge where stop==1; a cmt_valid in that same cycle is still pushed (REQ-010 rules).
REQ-018 SHALL ignore cmt_valid in DRAIN and HALTED (no push, no drop count).
REQ-019 SHALL go DRAIN->HALTED on the edge where count==0 after that cycle's pop; HALTED is terminal until reset.
REQ-020 SHALL drive halted=1 only in HALTED; stop is ignored outside RUN.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; full/empty by separate count register of width log2(DEPTH)+1.

Reset
REQ-022 SHALL on resetn==0 at an edge clear pointers, count, inst_cnt, drop_cnt, overflow, set state RUN; reset mid-drain discards all entries.
REQ-023 SHALL drive out_valid=0, halted=0, overflow=0, drop_cnt=0, inst_cnt=0 after reset; entry storage is not reset, out_* data undefined while out_valid=0.

Configuration
REQ-024 SHALL, with CMT_TRACE_CYCLE_EN defined, add a 64-bit free-running cycle counter (0 after reset, +1 every cycle) stored per entry and output on port out_cycle (64, out).
REQ-025 SHALL, without CMT_TRACE_CYCLE_EN, omit the counter, the per-entry field and the out_cycle port entirely.

Structure
REQ-026 SHALL place in package cmt_trace_pkg: cmt_rec_t record typedef (pc, inst, exp, mret, rf_wen, rf_wnum, rf_wdata, seq, optional cycle), state enum, DEPTH default.
REQ-027 SHALL implement storage as one sub-module cmt_fifo (generic push/pop, count, full/empty); FSM and counters in commit_trace.

Verification
REQ-028 SHALL test: single commit pc=0x80000000 inst=0x00000413, out_ready=1 -> out_valid next cycle, out_seq=0, inst_cnt=1.
REQ-029 SHALL test: 10 back-to-back commits, out_ready=0, DEPTH=8 -> 8 stored, overflow=1, drop_cnt=2, pops yield seq 0..7.
REQ-030 SHALL test: FIFO full, out_ready=1 and cmt_valid=1 every cycle for 20 cycles -> no drops, seq strictly increasing by 1.
REQ-031 SHALL test: 3 entries queued, stop=1 with cmt_valid=1 -> 4th pushed, later commits ignored, halted=1 one edge after 4th pop.
REQ-032 SHALL test: resetn=0 during DRAIN with 5 entries -> next cycle out_valid=0, state RUN, inst_cnt=0; with CMT_TRACE_CYCLE_EN, first record after reset at cycle 3 shows out_cycle=3.
